// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types; fetch packet carried from if_stage through fetch_queue.
// Latency: n/a (types only). Backpressure: n/a.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef struct packed {
        lc3b_word pc;
        lc3b_word inst;
    } lc3b_fetch_pkt;

    localparam int FETCH_QUEUE_DEPTH = 4;

endpackage

// File: rtl/fetch_queue_ram.sv
// DEPTH x 32 fetch packet storage: one synchronous write port, one asynchronous read port, no reset.
// Latency: write visible on read port after the writing edge. Backpressure: none, caller owns flow control.
module fetch_queue_ram #(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Decoupling FIFO of {pc, inst} packets between if_stage and id_stage; flush empties it in one edge.
// Latency: 1 cycle, or 0 when FETCH_QUEUE_BYPASS_EN is defined and the queue is empty.
// Backpressure: in_ready = !full (no push-through-pop when full); out_ready ignored while empty.
module fetch_queue
    import lc3b_types::*;
#(
    parameter int DEPTH = FETCH_QUEUE_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [15:0]                in_pc,
    input  logic [15:0]                in_inst,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [15:0]                out_pc,
    output logic [15:0]                out_inst,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic          bypass;
    lc3b_fetch_pkt in_pkt;
    lc3b_fetch_pkt head_pkt;
    lc3b_fetch_pkt out_pkt;

    assign in_pkt   = '{pc: in_pc, inst: in_inst};
    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign in_ready = !full;

`ifdef FETCH_QUEUE_BYPASS_EN
    // Reset is excluded so the queue reports idle outputs while rst is held.
    assign bypass = empty & in_valid & !flush & !rst;
`else
    assign bypass = 1'b0;
`endif

    assign out_valid = !empty | bypass;
    assign push      = in_valid & in_ready & !flush & !(bypass & out_ready);
    assign pop       = out_valid & out_ready & !flush & !empty;

    always_comb begin
        out_pkt = '0;
        if (bypass) begin
            out_pkt = in_pkt;
        end else if (!empty) begin
            out_pkt = head_pkt;
        end
    end

    assign out_pc   = out_pkt.pc;
    assign out_inst = out_pkt.inst;

    fetch_queue_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (push & !rst),
        .waddr (wr_ptr),
        .wdata (in_pkt),
        .raddr (rd_ptr),
        .rdata (head_pkt)
    );

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH=4); covers reset, fill/drain, wrap, full, flush and bypass latency.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_pc;
    logic [15:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_pc;
    logic [15:0] out_inst;
    logic [2:0]  count;
    logic        empty;
    logic        full;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .count     (count),
        .empty     (empty),
        .full      (full)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_pc = 16'h1111; in_inst = 16'h2222; out_ready = 1'b0;
        step();
        step();
        rst = 1'b0; in_valid = 1'b0;
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_pc", 32'(out_pc), 32'd0);
        check("rst_out_inst", 32'(out_inst), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);

        // Fill with decode stalled
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_pc = 16'h3000 + 16'(2 * i); in_inst = 16'hA000 + 16'(i);
            step();
        end
        check("fill_count", 32'(count), 32'd4);
        check("fill_full", 32'(full), 32'd1);
        check("fill_in_ready", 32'(in_ready), 32'd0);
        in_pc = 16'h3008; in_inst = 16'hA004;
        step();
        check("fifth_rejected_count", 32'(count), 32'd4);
        check("fifth_head_pc", 32'(out_pc), 32'h3000);

        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("drain_pc", 32'(out_pc), 32'h3000 + 32'(2 * i));
            check("drain_inst", 32'(out_inst), 32'hA000 + 32'(i));
            step();
        end
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_out_valid", 32'(out_valid), 32'd0);
        check("drain_out_pc_zero", 32'(out_pc), 32'd0);

        // Wrap: hold count at 2 with simultaneous push+pop
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_pc = 16'h6000 + 16'(2 * i); in_inst = 16'hB000 + 16'(i);
            step();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1; in_pc = 16'h6004 + 16'(2 * k); in_inst = 16'hB002 + 16'(k);
            #1;
            check("wrap_pc", 32'(out_pc), 32'h6000 + 32'(2 * k));
            check("wrap_count", 32'(count), 32'd2);
            step();
        end
        check("wrap_count_end", 32'(count), 32'd2);
        in_valid = 1'b0;
        #1;
        check("wrap_tail0_pc", 32'(out_pc), 32'h6014);
        check("wrap_tail0_inst", 32'(out_inst), 32'hB00A);
        step();
        check("wrap_tail1_pc", 32'(out_pc), 32'h6016);
        step();
        check("wrap_empty", 32'(empty), 32'd1);

        // Full with decode ready: pop only, then push next cycle
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_pc = 16'h7000 + 16'(2 * i); in_inst = 16'hC000 + 16'(i);
            step();
        end
        in_pc = 16'h7008; in_inst = 16'hC004; out_ready = 1'b1;
        #1;
        check("full_pop_in_ready", 32'(in_ready), 32'd0);
        step();
        check("full_pop_count", 32'(count), 32'd3);
        check("full_pop_head", 32'(out_pc), 32'h7002);
        out_ready = 1'b0;
        step();
        check("after_full_push_count", 32'(count), 32'd4);

        // Flush at count=3 with a concurrent push
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        check("pre_flush_count", 32'(count), 32'd3);
        flush = 1'b1; in_valid = 1'b1; in_pc = 16'h4000; in_inst = 16'hD000; out_ready = 1'b0;
        step();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        check("flush_count", 32'(count), 32'd0);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_out_pc", 32'(out_pc), 32'd0);
        step();
        check("flush_no_ghost_pc", 32'(out_pc), 32'd0);

        // Empty-queue latency: zero with bypass, one cycle without
        in_valid = 1'b1; in_pc = 16'h5000; in_inst = 16'h5555; out_ready = 1'b1;
        #1;
`ifdef FETCH_QUEUE_BYPASS_EN
        check("bypass_out_valid", 32'(out_valid), 32'd1);
        check("bypass_out_pc", 32'(out_pc), 32'h5000);
        check("bypass_out_inst", 32'(out_inst), 32'h5555);
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        check("bypass_count", 32'(count), 32'd0);
        check("bypass_after_valid", 32'(out_valid), 32'd0);
`else
        check("nobypass_out_valid", 32'(out_valid), 32'd0);
        check("nobypass_out_pc", 32'(out_pc), 32'd0);
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        check("nobypass_next_valid", 32'(out_valid), 32'd1);
        check("nobypass_next_pc", 32'(out_pc), 32'h5000);
        check("nobypass_count", 32'(count), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
